// File: rtl/interboard_pkg.sv
// interboard_pkg: definitions shared by both halves of the board-to-board link
// (the sender here and the far-side receiver).
//   - message type codes carried in the header beat
//   - position of the header flag inside a 6-bit beat
//   - transmit-side state encoding
//   - beat encoders, so both ends agree on the frame layout
package interboard_pkg;

  // Message type codes (3 bits, carried in beat0[2:0])
  localparam logic [2:0] MSG_RESET  = 3'd0;
  localparam logic [2:0] MSG_START  = 3'd1;
  localparam logic [2:0] MSG_SELECT = 3'd2;
  localparam logic [2:0] MSG_GUESS  = 3'd3;
  localparam logic [2:0] MSG_WIN    = 3'd4;
  localparam logic [2:0] MSG_ACKNUM = 3'd5;

  // Bit 5 of a beat marks the header (first) beat of a frame
  localparam int HDR_BIT = 5;

  // Transmit sequencer states
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SETUP   = 3'd1,
    WAIT_HI = 3'd2,
    WAIT_LO = 3'd3,
    RECOVER = 3'd4
  } tx_state_t;

  // Header beat: flag set, two reserved zero bits, then the message type
  function automatic logic [5:0] enc_beat0(input logic [2:0] msg_type);
    logic [5:0] w_beat;
    w_beat          = {3'b000, msg_type};
    w_beat[HDR_BIT] = 1'b1;
    return w_beat;
  endfunction

  // Payload beat: flag clear, then the 5-bit number
  function automatic logic [5:0] enc_beat1(input logic [4:0] number);
    return {1'b0, number};
  endfunction

  // True when the type code is one the link defines (codes 6 and 7 are spare)
  function automatic logic is_known_msg(input logic [2:0] msg_type);
    logic w_known;
    case (msg_type)
      MSG_RESET, MSG_START, MSG_SELECT,
      MSG_GUESS, MSG_WIN, MSG_ACKNUM: w_known = 1'b1;
      default:                        w_known = 1'b0;
    endcase
    return w_known;
  endfunction

endpackage

// File: rtl/sync_ff.sv
// sync_ff: multi-flop synchroniser for a single asynchronous level.
// Used for Ack_in on the sender and reusable for Request_in on the receiver.
// Ports:
//   clk      - destination clock
//   rst      - synchronous, active-high reset (clears every stage)
//   i_async  - asynchronous input level
//   o_sync   - input level delayed by SYNC_STAGES clocks, safe to use in clk domain
module sync_ff #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic i_async,
  output logic o_sync
);

  logic [SYNC_STAGES-1:0] r_sync;

  // Shift chain: stage 0 may go metastable, later stages give it time to settle
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync <= {SYNC_STAGES{1'b0}};
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
    end
  end

  assign o_sync = r_sync[SYNC_STAGES-1];

endmodule

// File: rtl/interboard_sender.sv
// interboard_sender: transmit half of the board-to-board link.
// Takes one control message (type + number) from the local game controller and
// sends it as a two-beat frame over a four-phase Request/Ack handshake.
// Ports:
//   clk            - system clock
//   rst            - synchronous, active-high reset
//   ctrl_en        - one-cycle strobe: send {ctrl_msg_type, ctrl_number}
//   ctrl_msg_type  - message type, sampled when ctrl_en && inter_ready
//   ctrl_number    - payload number (0..24), sampled with ctrl_msg_type
//   inter_ready    - high when idle and able to accept ctrl_en
//   Ack_in         - asynchronous acknowledge from the far board
//   Request_out    - four-phase request to the far board
//   inter_data_out - current beat to the far board
//   tx_done        - one-cycle pulse: frame fully acknowledged
//   tx_error       - one-cycle pulse: frame aborted on Ack timeout
module interboard_sender
  import interboard_pkg::*;
#(
  parameter int SETUP_CYCLES = 1,
  parameter int ACK_TIMEOUT  = 1_000_000,
  parameter int SYNC_STAGES  = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ctrl_en,
  input  logic [2:0] ctrl_msg_type,
  input  logic [4:0] ctrl_number,
  output logic       inter_ready,
  input  logic       Ack_in,
  output logic       Request_out,
  output logic [5:0] inter_data_out,
  output logic       tx_done,
  output logic       tx_error
);

  localparam int TIMER_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam int SETUP_W = (SETUP_CYCLES > 1) ? $clog2(SETUP_CYCLES) : 1;
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(ACK_TIMEOUT - 1);
  localparam logic [SETUP_W-1:0] SETUP_LAST = SETUP_W'(SETUP_CYCLES - 1);

  tx_state_t            r_state;
  logic                 r_beat;       // 0 = header beat in flight, 1 = payload beat
  logic [TIMER_W-1:0]   r_timer;      // cycles spent waiting for the current Ack edge
  logic [SETUP_W-1:0]   r_setup_cnt;  // cycles data has been stable before Request
  logic [4:0]           r_number;     // payload held until the second beat
  logic                 r_request;
  logic [5:0]           r_data;
  logic                 r_ready;
  logic                 r_done;
  logic                 r_error;
  logic                 w_ack_sync;

  sync_ff #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_ack_sync (
    .clk     (clk),
    .rst     (rst),
    .i_async (Ack_in),
    .o_sync  (w_ack_sync)
  );

  // Frame sequencer: state, beat, timers and every registered output
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_beat      <= 1'b0;
      r_timer     <= {TIMER_W{1'b0}};
      r_setup_cnt <= {SETUP_W{1'b0}};
      r_number    <= 5'd0;
      r_request   <= 1'b0;
      r_data      <= 6'd0;
      r_ready     <= 1'b1;
      r_done      <= 1'b0;
      r_error     <= 1'b0;
    end else begin
      // Status outputs are single-cycle pulses unless set below
      r_done  <= 1'b0;
      r_error <= 1'b0;

      case (r_state)
        IDLE: begin
          r_request <= 1'b0;
          if (ctrl_en) begin
            // Header goes on the bus right away so it has the full setup window
            r_data      <= enc_beat0(ctrl_msg_type);
            r_number    <= ctrl_number;
            r_beat      <= 1'b0;
            r_setup_cnt <= {SETUP_W{1'b0}};
            r_ready     <= 1'b0;
            r_state     <= SETUP;
          end else begin
            r_ready <= 1'b1;
          end
        end

        SETUP: begin
          if (r_setup_cnt == SETUP_LAST) begin
            r_request <= 1'b1;
            r_timer   <= {TIMER_W{1'b0}};
            r_state   <= WAIT_HI;
          end else begin
            r_setup_cnt <= r_setup_cnt + SETUP_W'(1);
          end
        end

        WAIT_HI: begin
          if (w_ack_sync) begin
            r_request <= 1'b0;
            r_timer   <= {TIMER_W{1'b0}};
            r_state   <= WAIT_LO;
          end else if (r_timer == TIMER_LAST) begin
            // Ack is still low here, so nothing to wait out: abort straight to idle
            r_error   <= 1'b1;
            r_request <= 1'b0;
            r_data    <= 6'd0;
            r_beat    <= 1'b0;
            r_ready   <= 1'b1;
            r_state   <= IDLE;
          end else begin
            r_timer <= r_timer + TIMER_W'(1);
          end
        end

        WAIT_LO: begin
          if (!w_ack_sync) begin
            if (!r_beat) begin
              // Header acknowledged: present the payload and run a fresh setup window
              r_beat      <= 1'b1;
              r_data      <= enc_beat1(r_number);
              r_setup_cnt <= {SETUP_W{1'b0}};
              r_state     <= SETUP;
            end else begin
              r_done  <= 1'b1;
              r_data  <= 6'd0;
              r_beat  <= 1'b0;
              r_ready <= 1'b1;
              r_state <= IDLE;
            end
          end else if (r_timer == TIMER_LAST) begin
            // Ack is stuck high: park until the far side releases it
            r_error   <= 1'b1;
            r_request <= 1'b0;
            r_data    <= 6'd0;
            r_beat    <= 1'b0;
            r_state   <= RECOVER;
          end else begin
            r_timer <= r_timer + TIMER_W'(1);
          end
        end

        RECOVER: begin
          r_request <= 1'b0;
          if (!w_ack_sync) begin
            r_ready <= 1'b1;
            r_state <= IDLE;
          end else begin
            r_ready <= 1'b0;
          end
        end

        default: begin
          r_state   <= IDLE;
          r_request <= 1'b0;
          r_data    <= 6'd0;
          r_beat    <= 1'b0;
          r_ready   <= 1'b1;
        end
      endcase
    end
  end

  assign inter_ready    = r_ready;
  assign Request_out    = r_request;
  assign inter_data_out = r_data;
  assign tx_done        = r_done;
  assign tx_error       = r_error;

endmodule

// File: tb/tb_interboard_sender.sv
// Self-checking bench for interboard_sender: table-driven frames, directed
// multi-cycle sequences (timing, back-to-back, busy, timeout, recover, reset)
// and randomized frames checked against a beat-level model.
module tb_interboard_sender;

  localparam int SETUP_CYCLES = 1;
  localparam int ACK_TIMEOUT  = 16;
  localparam int SYNC_STAGES  = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       ctrl_en;
  logic [2:0] ctrl_msg_type;
  logic [4:0] ctrl_number;
  logic       inter_ready;
  logic       Ack_in;
  logic       Request_out;
  logic [5:0] inter_data_out;
  logic       tx_done;
  logic       tx_error;

  logic resp_en  = 1'b0;
  logic man_ack  = 1'b0;
  logic auto_ack = 1'b0;
  int   resp_delay = 3;

  int n_chk    = 0;
  int n_pass   = 0;
  int done_cnt = 0;
  int err_cnt  = 0;

  logic [5:0] obs[$];
  logic [5:0] exp_q[$];
  logic       prev_req  = 1'b0;
  logic [5:0] prev_data = 6'd0;

  typedef struct {
    logic [2:0] t;
    logic [4:0] n;
    logic [5:0] b0;
    logic [5:0] b1;
  } vec_t;
  vec_t vecs[6];

  assign Ack_in = resp_en ? auto_ack : man_ack;

  interboard_sender #(
    .SETUP_CYCLES (SETUP_CYCLES),
    .ACK_TIMEOUT  (ACK_TIMEOUT),
    .SYNC_STAGES  (SYNC_STAGES)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .ctrl_en        (ctrl_en),
    .ctrl_msg_type  (ctrl_msg_type),
    .ctrl_number    (ctrl_number),
    .inter_ready    (inter_ready),
    .Ack_in         (Ack_in),
    .Request_out    (Request_out),
    .inter_data_out (inter_data_out),
    .tx_done        (tx_done),
    .tx_error       (tx_error)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Beat model: header = 32 + type, payload = number
  function automatic logic [5:0] mdl_beat0(input logic [2:0] t);
    return 6'(32 + int'(t));
  endfunction
  function automatic logic [5:0] mdl_beat1(input logic [4:0] n);
    return 6'(int'(n));
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  // Far-board responder: follows Request_out after resp_delay cycles
  initial begin
    int cnt;
    cnt = 0;
    forever begin
      @(posedge clk);
      #1;
      if (resp_en) begin
        if (auto_ack != Request_out) begin
          cnt++;
          if (cnt >= resp_delay) begin
            auto_ack = Request_out;
            cnt = 0;
          end
        end else begin
          cnt = 0;
        end
      end else begin
        auto_ack = 1'b0;
        cnt = 0;
      end
    end
  end

  // Bus monitor: records each beat at Request rise and checks data stability
  always @(negedge clk) begin
    if (Request_out && !prev_req) obs.push_back(inter_data_out);
    if (Request_out && prev_req) check("req_data_stable", inter_data_out, prev_data);
    if (tx_done) done_cnt++;
    if (tx_error) err_cnt++;
    prev_req  = Request_out;
    prev_data = inter_data_out;
  end

  task automatic wait_done(input int budget, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      if (tx_done) begin
        ok = 1'b1;
        break;
      end
    end
    cyc();
  endtask

  task automatic send_frame(input logic [2:0] t, input logic [4:0] n, input bit inject, output bit ok);
    ctrl_msg_type = t;
    ctrl_number   = n;
    ctrl_en       = 1'b1;
    cyc();
    ctrl_en = 1'b0;
    ok = 1'b0;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (tx_done) begin
        ok = 1'b1;
        break;
      end
      if (inject && k == 3) begin
        ctrl_msg_type = 3'd7;
        ctrl_number   = 5'd31;
        ctrl_en       = 1'b1;
      end else begin
        ctrl_en = 1'b0;
      end
    end
    ctrl_en = 1'b0;
    cyc();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    bit flag;

    vecs[0] = '{3'd3, 5'd17, 6'b100011, 6'b010001};
    vecs[1] = '{3'd2, 5'd0,  6'b100010, 6'b000000};
    vecs[2] = '{3'd4, 5'd9,  6'b100100, 6'b001001};
    vecs[3] = '{3'd5, 5'd24, 6'b100101, 6'b011000};
    vecs[4] = '{3'd0, 5'd1,  6'b100000, 6'b000001};
    vecs[5] = '{3'd1, 5'd12, 6'b100001, 6'b001100};

    rst = 1'b1; ctrl_en = 1'b0; ctrl_msg_type = 3'd0; ctrl_number = 5'd0;
    cyc(); cyc(); cyc();
    smp();
    check("rst_req", Request_out, 1'b0);
    check("rst_data", inter_data_out, 6'd0);
    check("rst_ready", inter_ready, 1'b1);
    check("rst_done", tx_done, 1'b0);
    check("rst_err", tx_error, 1'b0);
    cyc();
    rst = 1'b0;
    smp();
    check("post_rst_ready", inter_ready, 1'b1);

    // Single frame with exact Ack latency, then back-to-back in the tx_done cycle
    obs.delete(); done_cnt = 0;
    cyc();
    ctrl_msg_type = 3'd3; ctrl_number = 5'd17; ctrl_en = 1'b1;
    cyc(); ctrl_en = 1'b0;
    smp();
    check("t1_beat0", inter_data_out, 6'b100011);
    check("t1_busy", inter_ready, 1'b0);
    check("t1_req_setup", Request_out, 1'b0);
    cyc(); smp();
    check("t1_req_rise", Request_out, 1'b1);
    cyc(); man_ack = 1'b1;
    cyc();
    cyc(); smp();
    check("t1_req_hold_sync", Request_out, 1'b1);
    cyc(); smp();
    check("t1_req_fall", Request_out, 1'b0);
    check("t1_beat0_after_fall", inter_data_out, 6'b100011);
    cyc(); man_ack = 1'b0;
    cyc();
    cyc(); smp();
    check("t1_beat0_hold", inter_data_out, 6'b100011);
    cyc(); smp();
    check("t1_beat1", inter_data_out, 6'b010001);
    check("t1_req_low_b1", Request_out, 1'b0);
    cyc(); smp();
    check("t1_req_rise_b1", Request_out, 1'b1);
    cyc(); man_ack = 1'b1;
    cyc(); cyc(); cyc(); smp();
    check("t1_req_fall_b1", Request_out, 1'b0);
    cyc(); man_ack = 1'b0;
    cyc(); cyc(); cyc();
    ctrl_msg_type = 3'd2; ctrl_number = 5'd0; ctrl_en = 1'b1;
    smp();
    check("t1_done", tx_done, 1'b1);
    check("t1_ready_at_done", inter_ready, 1'b1);
    check("t1_data_cleared", inter_data_out, 6'd0);
    cyc(); ctrl_en = 1'b0;
    smp();
    check("t2_beat0", inter_data_out, 6'b100010);
    check("t2_busy", inter_ready, 1'b0);
    check("t2_done_pulse", tx_done, 1'b0);
    check("t1_nbeats", obs.size(), 2);
    if (obs.size() >= 2) begin
      check("t1_obs0", obs[0], 6'b100011);
      check("t1_obs1", obs[1], 6'b010001);
    end
    check("t1_done_once", done_cnt, 1);
    resp_delay = 3; resp_en = 1'b1;
    wait_done(200, ok);
    check("t2_finished", ok, 1'b1);
    check("t2_nbeats", obs.size(), 4);
    if (obs.size() >= 4) begin
      check("t2_obs0", obs[2], 6'b100010);
      check("t2_obs1", obs[3], 6'b000000);
    end

    // Table-driven frames
    for (int i = 0; i < 6; i++) begin
      resp_delay = 1 + (i % 4);
      obs.delete(); done_cnt = 0;
      check("tab_ready_before", inter_ready, 1'b1);
      send_frame(vecs[i].t, vecs[i].n, 1'b0, ok);
      check("tab_done", ok, 1'b1);
      check("tab_nbeats", obs.size(), 2);
      if (obs.size() >= 2) begin
        check("tab_beat0", obs[0], vecs[i].b0);
        check("tab_beat1", obs[1], vecs[i].b1);
      end
      check("tab_done_once", done_cnt, 1);
      check("tab_ready_after", inter_ready, 1'b1);
    end

    // Busy rejection: a second strobe during WAIT_HI is dropped
    resp_delay = 4; obs.delete(); done_cnt = 0;
    ctrl_msg_type = 3'd6; ctrl_number = 5'd20; ctrl_en = 1'b1;
    cyc(); ctrl_en = 1'b0;
    cyc();
    ctrl_msg_type = 3'd4; ctrl_number = 5'd9; ctrl_en = 1'b1;
    smp();
    check("busy_req_hi", Request_out, 1'b1);
    check("busy_ready0", inter_ready, 1'b0);
    cyc(); ctrl_en = 1'b0;
    smp();
    check("busy_ready0_b", inter_ready, 1'b0);
    wait_done(200, ok);
    check("busy_done", ok, 1'b1);
    repeat (15) cyc();
    check("busy_nbeats", obs.size(), 2);
    if (obs.size() >= 2) begin
      check("busy_beat0", obs[0], 6'b100110);
      check("busy_beat1", obs[1], 6'b010100);
    end
    check("busy_done_once", done_cnt, 1);
    resp_en = 1'b0;

    // Timeout in WAIT_HI: Ack never rises
    man_ack = 1'b0; err_cnt = 0; done_cnt = 0;
    cyc();
    ctrl_msg_type = 3'd6; ctrl_number = 5'd3; ctrl_en = 1'b1;
    cyc(); ctrl_en = 1'b0;
    cyc(); smp();
    check("to_req_hi", Request_out, 1'b1);
    flag = 1'b0;
    for (int k = 3; k <= 17; k++) begin
      cyc(); smp();
      if (tx_error) flag = 1'b1;
    end
    check("to_no_early_err", flag, 1'b0);
    cyc(); smp();
    check("to_err", tx_error, 1'b1);
    check("to_req_low", Request_out, 1'b0);
    cyc(); smp();
    check("to_ready_next", inter_ready, 1'b1);
    check("to_err_pulse", tx_error, 1'b0);
    check("to_err_once", err_cnt, 1);
    check("to_no_done", done_cnt, 0);

    // Late Ack: stuck high past timeout, released 20 cycles later
    err_cnt = 0;
    cyc();
    ctrl_msg_type = 3'd1; ctrl_number = 5'd5; ctrl_en = 1'b1;
    cyc(); ctrl_en = 1'b0;
    cyc();
    cyc(); man_ack = 1'b1;
    ok = 1'b0;
    for (int k = 0; k < 60; k++) begin
      smp();
      if (tx_error) begin
        ok = 1'b1;
        break;
      end
      cyc();
    end
    check("late_err_seen", ok, 1'b1);
    check("late_req_low", Request_out, 1'b0);
    flag = 1'b0;
    for (int k = 0; k < 20; k++) begin
      cyc(); smp();
      if (inter_ready) flag = 1'b1;
    end
    check("late_recover_busy", flag, 1'b0);
    cyc(); man_ack = 1'b0;
    smp(); check("late_ready_t0", inter_ready, 1'b0);
    cyc(); smp(); check("late_ready_t1", inter_ready, 1'b0);
    cyc(); smp(); check("late_ready_t2", inter_ready, 1'b0);
    cyc(); smp(); check("late_ready_t3", inter_ready, 1'b1);
    check("late_err_once", err_cnt, 1);
    check("late_no_done", done_cnt, 0);

    // Reset in WAIT_LO of the header beat
    err_cnt = 0; done_cnt = 0;
    cyc();
    ctrl_msg_type = 3'd3; ctrl_number = 5'd17; ctrl_en = 1'b1;
    cyc(); ctrl_en = 1'b0;
    cyc();
    cyc(); man_ack = 1'b1;
    cyc(); cyc();
    cyc(); rst = 1'b1;
    smp();
    check("rmid_in_wait_lo_req", Request_out, 1'b0);
    check("rmid_in_wait_lo_data", inter_data_out, 6'b100011);
    cyc(); rst = 1'b0; man_ack = 1'b0;
    smp();
    check("rmid_req", Request_out, 1'b0);
    check("rmid_data", inter_data_out, 6'd0);
    check("rmid_ready", inter_ready, 1'b1);
    check("rmid_done", tx_done, 1'b0);
    check("rmid_err", tx_error, 1'b0);
    repeat (4) cyc();
    check("rmid_no_pulses", done_cnt + err_cnt, 0);

    // Randomized frames against the beat model, some with busy strobes
    resp_en = 1'b1;
    for (int i = 0; i < 25; i++) begin
      logic [2:0] t;
      logic [4:0] n;
      t = 3'($urandom_range(0, 7));
      n = 5'($urandom_range(0, 24));
      resp_delay = $urandom_range(1, 5);
      exp_q.delete(); obs.delete(); done_cnt = 0;
      exp_q.push_back(mdl_beat0(t));
      exp_q.push_back(mdl_beat1(n));
      check("rnd_ready", inter_ready, 1'b1);
      send_frame(t, n, (i % 3) == 0, ok);
      check("rnd_done", ok, 1'b1);
      check("rnd_nbeats", obs.size(), exp_q.size());
      for (int j = 0; j < exp_q.size() && j < obs.size(); j++)
        check("rnd_beat", obs[j], exp_q[j]);
      check("rnd_done_once", done_cnt, 1);
    end
    resp_en = 1'b0;
    repeat (3) cyc();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
